frame_parser: RTL

FRAME_PARSER -- requirements
Module: frame_parser

---
 rtl/frame_parser_if.sv | 23 ++
 rtl/frame_parser.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/frame_parser_if.sv
// Byte-stream receive port and parsed-frame result bus of the frame parser.
// The master side feeds bytes and observes results; the slave side is the parser.
interface frame_parser_if;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic [7:0]   cmd;
   logic         valid;
   logic [127:0] uid_bytes_flat;
   logic [7:0]   uid_len;
   logic         frame_err;
   logic [1:0]   err_code;
   logic         busy;

   modport master (
      output rx_data, rx_valid,
      input  cmd, valid, uid_bytes_flat, uid_len, frame_err, err_code, busy
   );

   modport slave (
      input  rx_data, rx_valid,
      output cmd, valid, uid_bytes_flat, uid_len, frame_err, err_code, busy
   );
endinterface

// File: rtl/frame_parser.sv
// Parses SOF/CMD/LEN/payload/CHK frames from a byte stream, checking the XOR
// checksum, payload length and inter-byte timeout; results publish only on good frames.
module frame_parser #(
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input logic           clk,
   input logic           rst,
   frame_parser_if.slave bus
);

   localparam int unsigned     TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TMO_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CHK
   } state_e;

   state_e           state_q;
   logic [7:0]       cmd_sh_q;
   logic [7:0]       len_sh_q;
   logic [7:0]       chk_q;
   logic [15:0][7:0] buf_q;
   logic [3:0]       idx_q;
   logic [TW-1:0]    tmo_q;

   logic [7:0]       cmd_q;
   logic [7:0]       uid_len_q;
   logic [127:0]     uid_q;
   logic             valid_q;
   logic             err_q;
   logic [1:0]       err_code_q;

   logic [7:0]       rx_byte;
   logic             last_payload;

   assign rx_byte      = bus.rx_data;
   assign last_payload = ({4'd0, idx_q} == (len_sh_q - 8'd1));

   // NOTE: every register here is assigned with <= so all updates in this block
   // see the pre-edge values; a blocking = would leak new values into later reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cmd_sh_q   <= '0;
         len_sh_q   <= '0;
         chk_q      <= '0;
         // NOTE: the shadow payload buffer is reset as well, so no bytes from a
         // frame cut short by reset can ever reach uid_bytes_flat.
         buf_q      <= '0;
         idx_q      <= '0;
         tmo_q      <= '0;
         cmd_q      <= '0;
         uid_len_q  <= '0;
         uid_q      <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;

         if (state_q == S_IDLE || bus.rx_valid) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + TMO_ONE;
         end

         // Timeout wins over a byte landing in the same cycle; that byte is dropped.
         if (state_q != S_IDLE && tmo_q == TMO_LIMIT) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
         end else if (bus.rx_valid) begin
            unique case (state_q)
               S_IDLE: begin
                  if (rx_byte == SOF_BYTE) begin
                     state_q <= S_CMD;
                  end
               end
               S_CMD: begin
                  cmd_sh_q <= rx_byte;
                  chk_q    <= rx_byte;
                  buf_q    <= '0;
                  state_q  <= S_LEN;
               end
               S_LEN: begin
                  len_sh_q <= rx_byte;
                  chk_q    <= chk_q ^ rx_byte;
                  idx_q    <= '0;
                  if (rx_byte > MAX_LEN_B) begin
                     state_q    <= S_IDLE;
                     err_q      <= 1'b1;
                     err_code_q <= 2'd2;
                  end else if (rx_byte == 8'd0) begin
                     state_q <= S_CHK;
                  end else begin
                     state_q <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  buf_q[idx_q] <= rx_byte;
                  chk_q        <= chk_q ^ rx_byte;
                  idx_q        <= idx_q + 4'd1;
                  if (last_payload) begin
                     state_q <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (rx_byte == chk_q) begin
                     valid_q   <= 1'b1;
                     cmd_q     <= cmd_sh_q;
                     uid_len_q <= len_sh_q;
                     uid_q     <= buf_q;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'd1;
                  end
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.cmd            = cmd_q;
   assign bus.valid          = valid_q;
   assign bus.uid_bytes_flat = uid_q;
   assign bus.uid_len        = uid_len_q;
   assign bus.frame_err      = err_q;
   assign bus.err_code       = err_code_q;
   assign bus.busy           = (state_q != S_IDLE);

endmodule
